sync_spram_port_ctrl: RTL and testbench

//  Front-end controller driving one sync_spram instance (1-cycle fixed read latency, byte write enables).

---
 rtl/sync_spram_pkg.sv | 20 ++
 rtl/sync_spram.sv | 34 +++
 rtl/sync_spram_rsp_buf.sv | 43 ++++
 rtl/sync_spram_port_ctrl.sv | 124 ++++++++++++
 tb/tb_sync_spram_port_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_spram_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_spram_pkg: shared FSM encoding and credit helper for the
// sync_spram front-end controller.            Rev 1.0
// ------------------------------------------------------------------
package sync_spram_pkg;

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } spram_ctrl_state_e;

   // Outstanding reads are capped at the response buffer depth.
   function automatic logic credit_ok(input logic inflight, input logic [1:0] cnt);
      return ({1'b0, cnt} + {2'b00, inflight}) < 3'd2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_spram.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_spram: single-port RAM, 1-cycle read latency, byte enables,
// read data reflects a same-cycle write.      Rev 1.0
// ------------------------------------------------------------------
module sync_spram #(
   parameter  int DATA_WIDTH = 32,
   parameter  int DATA_DEPTH = 1024,
   parameter  int BYTE_SIZE  = 8,
   localparam int AW         = $clog2(DATA_DEPTH),
   localparam int NB         = DATA_WIDTH / BYTE_SIZE
) (
   input  logic                  clk,
   input  logic [AW-1:0]         addr_i,
   input  logic [NB-1:0]         we_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
   logic [DATA_WIDTH-1:0] merged;

   for (genvar b = 0; b < NB; b++) begin : g_lane
      assign merged[b*BYTE_SIZE +: BYTE_SIZE] = we_i[b] ? wdata_i[b*BYTE_SIZE +: BYTE_SIZE]
                                                        : mem_q[addr_i][b*BYTE_SIZE +: BYTE_SIZE];
   end

   always_ff @(posedge clk) begin
      mem_q[addr_i] <= merged;
      rdata_o       <= merged;
   end

endmodule
`default_nettype wire

// File: rtl/sync_spram_rsp_buf.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_spram_rsp_buf: 2-entry response FIFO with head and count.
// Rev 1.0
// ------------------------------------------------------------------
module sync_spram_rsp_buf #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] head_o,
   output logic [1:0]            count_o
);

   logic [DATA_WIDTH-1:0] mem_q [2];
   logic                  rd_ptr_q;
   logic                  wr_ptr_q;
   logic [1:0]            count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) wr_ptr_q <= ~wr_ptr_q;
         if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/sync_spram_port_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_spram_port_ctrl: valid/ready request/response front end with
// zero-fill for one sync_spram instance.       Rev 1.0
// ------------------------------------------------------------------
module sync_spram_port_ctrl
   import sync_spram_pkg::*;
#(
   parameter  int DATA_WIDTH    = 32,
   parameter  int DATA_DEPTH    = 1024,
   parameter  int BYTE_SIZE     = 8,
   parameter  int INIT_ON_RESET = 1,
   localparam int AW            = $clog2(DATA_DEPTH),
   localparam int NB            = DATA_WIDTH / BYTE_SIZE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [AW-1:0]         req_addr_i,
   input  logic [NB-1:0]         req_we_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  init_done_o,
   output logic [AW-1:0]         ram_addr_o,
   output logic [NB-1:0]         ram_we_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

   typedef struct packed {
      logic [AW-1:0]         addr;
      logic [NB-1:0]         we;
      logic [DATA_WIDTH-1:0] wdata;
   } req_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DATA_DEPTH - 1);

   spram_ctrl_state_e     state_q, state_d;
   logic [AW-1:0]         init_cnt_q;
   logic [AW-1:0]         ram_addr_q;
   logic                  inflight_q, inflight_d;
   logic                  ready_q;
   logic                  accept;
   logic                  buf_push, buf_pop;
   logic [1:0]            buf_cnt, buf_cnt_d;
   logic [DATA_WIDTH-1:0] buf_head;
   req_t                  req, ram_req;

   assign req        = '{addr: req_addr_i, we: req_we_i, wdata: req_wdata_i};
   assign accept     = req_valid_i & ready_q & (state_q == S_RUN) & ~rst;
   assign inflight_d = accept & (req_we_i == '0);

   // In-flight data bypasses the buffer only when nothing older is queued.
   assign buf_pop   = rsp_ready_i & (buf_cnt != 2'd0);
   assign buf_push  = inflight_q & ~((buf_cnt == 2'd0) & rsp_ready_i);
   assign buf_cnt_d = buf_cnt + {1'b0, buf_push} - {1'b0, buf_pop};

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_INIT:  if (init_cnt_q == LAST_ADDR) state_d = S_RUN;
         S_RUN:   if (clear_i) state_d = S_DRAIN;
         S_DRAIN: if (!inflight_q && (buf_cnt == 2'd0)) state_d = S_INIT;
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
         init_cnt_q <= '0;
         inflight_q <= 1'b0;
         ready_q    <= 1'b0;
         ram_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= ((state_q == S_INIT) && (state_d == S_INIT)) ? init_cnt_q + AW'(1) : '0;
         inflight_q <= inflight_d;
         ready_q    <= (state_d == S_RUN) && credit_ok(inflight_d, buf_cnt_d);
         ram_addr_q <= ram_addr_o;
      end
   end

   always_comb begin
      ram_req = '{addr: ram_addr_q, we: '0, wdata: '0};
      if (!rst) begin
         if (state_q == S_INIT) begin
            ram_req = '{addr: init_cnt_q, we: {NB{1'b1}}, wdata: '0};
         end else if (accept) begin
            ram_req = req;
         end
      end
   end

   assign ram_addr_o  = ram_req.addr;
   assign ram_we_o    = ram_req.we;
   assign ram_wdata_o = ram_req.wdata;

   sync_spram_rsp_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rsp_buf (
      .clk     (clk),
      .rst     (rst),
      .push_i  (buf_push),
      .pop_i   (buf_pop),
      .data_i  (ram_rdata_i),
      .head_o  (buf_head),
      .count_o (buf_cnt)
   );

   assign req_ready_o = ready_q & ~rst;
   assign rsp_valid_o = ~rst & ((buf_cnt != 2'd0) | inflight_q);
   assign rsp_rdata_o = (buf_cnt != 2'd0) ? buf_head : ram_rdata_i;
   assign init_done_o = ~rst & (state_q != S_INIT);

   a_no_full_inflight : assert property (@(posedge clk) disable iff (rst)
      !((buf_cnt == 2'd2) && inflight_q));

endmodule
`default_nettype wire

// File: tb/tb_sync_spram_port_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_sync_spram_port_ctrl: controller + sync_spram against a
// transaction-level model.                     Rev 1.0
// ------------------------------------------------------------------
module tb_sync_spram_port_ctrl;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int BYTE  = 8;
   localparam int AW    = 4;
   localparam int NB    = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clear = 1'b0;
   logic          req_valid = 1'b0;
   logic          rsp_ready = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [NB-1:0] req_we = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          req_ready, rsp_valid, init_done;
   logic [DW-1:0] rsp_rdata, ram_wdata, ram_rdata;
   logic [AW-1:0] ram_addr;
   logic [NB-1:0] ram_we;

   always #5 clk = ~clk;

   sync_spram_port_ctrl #(
      .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .BYTE_SIZE(BYTE), .INIT_ON_RESET(1)
   ) dut (
      .clk(clk), .rst(rst), .clear_i(clear),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
      .req_we_i(req_we), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .init_done_o(init_done),
      .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata),
      .ram_rdata_i(ram_rdata)
   );

   sync_spram #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .BYTE_SIZE(BYTE)) u_ram (
      .clk(clk), .addr_i(ram_addr), .we_i(ram_we), .wdata_i(ram_wdata), .rdata_o(ram_rdata)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Transaction-level model: outstanding reads as a queue of values, memory as an array.
   logic [DW-1:0] m_mem [DEPTH];
   logic [DW-1:0] m_q [$];
   int            m_init_left = 0;
   bit            m_drain = 1'b0;
   bit            m_acc = 1'b0;
   bit            started = 1'b0;
   int            start_sz;
   int            cyc = 0;

   function automatic bit exp_ready();
      return !rst && (m_init_left == 0) && !m_drain && (m_q.size() < 2);
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         m_acc = 1'b0;
         if (rst) begin
            m_q.delete();
            m_init_left = DEPTH;
            m_drain = 1'b0;
            foreach (m_mem[i]) m_mem[i] = '0;
         end else if (m_init_left > 0) begin
            m_init_left--;
         end else begin
            start_sz = m_q.size();
            m_acc = req_valid && exp_ready();
            if (start_sz > 0 && rsp_ready) void'(m_q.pop_front());
            if (m_acc) begin
               if (req_we == '0) m_q.push_back(m_mem[req_addr]);
               else for (int b = 0; b < NB; b++)
                  if (req_we[b]) m_mem[req_addr][b*BYTE +: BYTE] = req_wdata[b*BYTE +: BYTE];
            end
            if (m_drain) begin
               if (start_sz == 0) begin
                  m_drain = 1'b0;
                  m_init_left = DEPTH;
                  foreach (m_mem[i]) m_mem[i] = '0;
               end
            end else if (clear) begin
               m_drain = 1'b1;
            end
         end
         started = 1'b1;
      end
   end

   logic [NB-1:0] exp_we;
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            check("req_ready", 32'(req_ready), 32'(exp_ready()));
            check("rsp_valid", 32'(rsp_valid), 32'(!rst && (m_q.size() > 0)));
            if (!rst && m_q.size() > 0) check("rsp_rdata", rsp_rdata, m_q[0]);
            check("init_done", 32'(init_done), 32'(!rst && (m_init_left == 0)));
            if (rst) exp_we = '0;
            else if (m_init_left > 0) exp_we = '1;
            else if (req_valid && exp_ready()) exp_we = req_we;
            else exp_we = '0;
            check("ram_we", 32'(ram_we), 32'(exp_we));
            if (!rst && m_init_left > 0) begin
               check("init_addr", 32'(ram_addr), 32'(DEPTH - m_init_left));
               check("init_wdata", ram_wdata, 32'h0);
            end
         end
      end
   end

   logic [DW-1:0] got [$];
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && rsp_valid && rsp_ready) got.push_back(rsp_rdata);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [AW-1:0] a, input logic [NB-1:0] we, input logic [DW-1:0] d);
      req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = d;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (m_acc) begin
            req_valid = 1'b0;
            return;
         end
      end
      check("issue_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (m_q.size() == 0 && m_init_left == 0 && !m_drain) return;
         tick();
      end
      check("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic count_init(output int n);
      n = 0;
      for (int i = 0; i < 40 && init_done; i++) tick();
      for (int i = 0; i < 60 && !init_done; i++) begin
         tick();
         n++;
      end
   endtask

   int            n, base, c0;
   logic [DW-1:0] acc_or;

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      count_init(n);
      check("t1_init_cycles", 32'(n), 32'd16);

      rsp_ready = 1'b1;
      base = got.size();
      for (int a = 0; a < DEPTH; a++) issue(AW'(a), '0, '0);
      wait_idle();
      check("t1_rsp_count", 32'(got.size() - base), 32'd16);
      acc_or = '0;
      for (int i = base; i < got.size(); i++) acc_or |= got[i];
      check("t1_all_zero", acc_or, 32'h0);

      issue(4'd3, 4'b1111, 32'hDEADBEEF);
      issue(4'd3, 4'b0010, 32'h00001200);
      issue(4'd3, 4'b0000, '0);
      wait_idle();
      check("t2_rmw", got[got.size()-1], 32'hDEAD12EF);

      for (int a = 0; a < 8; a++) issue(AW'(a), 4'hF, DW'(a));
      base = got.size();
      c0 = cyc;
      for (int a = 0; a < 8; a++) issue(AW'(a), '0, '0);
      check("t3_issue_cycles", 32'(cyc - c0), 32'd8);
      wait_idle();
      check("t3_rsp_count", 32'(got.size() - base), 32'd8);
      for (int a = 0; a < 8; a++) check("t3_stream", got[base+a], 32'(a));

      rsp_ready = 1'b0;
      base = got.size();
      issue(4'd5, '0, '0);
      issue(4'd6, '0, '0);
      req_valid = 1'b1; req_addr = 4'd7; req_we = '0;
      repeat (3) tick();
      check("t4_ready_low", 32'(req_ready), 32'd0);
      rsp_ready = 1'b1;
      for (int i = 0; i < 20 && !m_acc; i++) tick();
      req_valid = 1'b0;
      wait_idle();
      check("t4_rsp_count", 32'(got.size() - base), 32'd3);
      check("t4_first", got[base], 32'd5);
      check("t4_second", got[base+1], 32'd6);
      check("t4_third", got[base+2], 32'd7);

      rsp_ready = 1'b0;
      base = got.size();
      issue(4'd1, '0, '0);
      issue(4'd2, '0, '0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      rsp_ready = 1'b1;
      count_init(n);
      check("t5_init_cycles", 32'(n), 32'd16);
      check("t5_rsp_a", got[base], 32'd1);
      check("t5_rsp_b", got[base+1], 32'd2);
      issue(4'd3, '0, '0);
      wait_idle();
      check("t5_cleared", got[got.size()-1], 32'h0);

      rsp_ready = 1'b0;
      issue(4'd4, '0, '0);
      issue(4'd5, '0, '0);
      tick();
      rst = 1'b1;
      tick();
      check("t6_valid_in_rst", 32'(rsp_valid), 32'd0);
      tick();
      rst = 1'b0;
      rsp_ready = 1'b1;
      base = got.size();
      count_init(n);
      check("t6_init_cycles", 32'(n), 32'd16);
      check("t6_no_stale", 32'(got.size() - base), 32'd0);

      for (int i = 0; i < 800; i++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_addr  = AW'($urandom_range(0, DEPTH-1));
         req_we    = ($urandom_range(0, 1) != 0) ? '0 : NB'($urandom_range(1, 15));
         req_wdata = $urandom;
         rsp_ready = ($urandom_range(0, 3) != 0);
         clear     = ($urandom_range(0, 79) == 0);
         tick();
      end
      req_valid = 1'b0;
      clear = 1'b0;
      rsp_ready = 1'b1;
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
